// File: rtl/tx_lane_arbiter_if.sv
// Request/transmit bundle of the lane arbiter: NREQ requesters in, one multi-lane tx stream out.
// slave = arbiter view, master = requester/downstream environment view.
interface tx_lane_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int LANS  = 4,
    parameter int DAT_W = 544,
    parameter int K_W   = 17
);
    logic [NREQ-1:0]       req_vld;
    logic [NREQ-1:0]       req_last;
    logic [NREQ*DAT_W-1:0] req_dat;
    logic [NREQ*K_W-1:0]   req_datk;
    logic [NREQ*LANS-1:0]  req_datv;
    logic [NREQ-1:0]       req_rdy;
    logic [DAT_W-1:0]      tdat;
    logic [K_W-1:0]        tdatk;
    logic [LANS-1:0]       tdatv;
    logic                  tvld;
    logic                  t_rdy;

    modport slave (
        input  req_vld, req_last, req_dat, req_datk, req_datv, t_rdy,
        output req_rdy, tdat, tdatk, tdatv, tvld
    );

    modport master (
        output req_vld, req_last, req_dat, req_datk, req_datv, t_rdy,
        input  req_rdy, tdat, tdatk, tdatv, tvld
    );
endinterface

// File: rtl/tx_lane_arbiter.sv
// Round-robin, packet-locking arbiter sharing one registered multi-lane tx stage between NREQ requesters.
// Optional per-requester beat counters are enabled by defining TX_LANE_ARBITER_STATS_EN.
module tx_lane_arbiter #(
    parameter int NREQ      = 4,
    parameter int LANS      = 4,
    parameter int DAT_W     = 544,
    parameter int K_W       = 17,
    parameter int MAX_BEATS = 16,
    localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    tx_lane_arbiter_if.slave   bus,
    output logic [IDW-1:0]     grant_id,
    output logic               busy
`ifdef TX_LANE_ARBITER_STATS_EN
    ,
    output logic [NREQ*32-1:0] stat_beats,
    input  logic               stat_clr
`endif
);

    localparam int CW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS + 1) : 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e          state_q;
    logic [IDW-1:0]  rrPtr_q;
    logic [IDW-1:0]  grantId_q;
    logic [CW-1:0]   beatCnt_q;
    logic            busy_q;
    logic            tvld_q;
    logic [DAT_W-1:0] tdat_q;
    logic [K_W-1:0]  tdatk_q;
    logic [LANS-1:0] tdatv_q;

    logic [IDW-1:0]  winner_d;
    logic [IDW-1:0]  nextPtr_d;
    logic [IDW-1:0]  idx;
    logic            found;
    logic            outFree;
    logic            accept;
    logic            quotaHit;
    logic            releaseNow;
    logic [DAT_W-1:0] selDat;
    logic [K_W-1:0]  selDatk;
    logic [LANS-1:0] selDatv;
    logic [NREQ-1:0] reqRdy_d;

    // First valid requester at or after the round-robin pointer, wrapping.
    always_comb begin
        winner_d = rrPtr_q;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(rrPtr_q) + k) % NREQ);
            if (!found && bus.req_vld[idx]) begin
                winner_d = idx;
                found    = 1'b1;
            end
        end
    end

    assign outFree    = ~tvld_q | bus.t_rdy;
    assign accept     = (state_q == BUSY) & bus.req_vld[grantId_q] & outFree;
    assign quotaHit   = (MAX_BEATS != 0) && ((32'(beatCnt_q) + 32'd1) == 32'(MAX_BEATS));
    assign releaseNow = accept & (bus.req_last[grantId_q] | quotaHit);
    assign nextPtr_d  = (grantId_q == IDW'(NREQ - 1)) ? '0 : grantId_q + IDW'(1);

    assign selDat  = bus.req_dat[int'(grantId_q) * DAT_W +: DAT_W];
    assign selDatk = bus.req_datk[int'(grantId_q) * K_W +: K_W];
    assign selDatv = bus.req_datv[int'(grantId_q) * LANS +: LANS];

    always_comb begin
        reqRdy_d = '0;
        if (state_q == BUSY) begin
            reqRdy_d[grantId_q] = outFree;
        end
    end

    // Grant FSM plus the single output register; the lock only ends on an accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rrPtr_q   <= '0;
            grantId_q <= '0;
            beatCnt_q <= '0;
            busy_q    <= 1'b0;
            tvld_q    <= 1'b0;
            tdat_q    <= '0;
            tdatk_q   <= '0;
            tdatv_q   <= '0;
        end else begin
            if (accept) begin
                tvld_q  <= 1'b1;
                tdat_q  <= selDat;
                tdatk_q <= selDatk;
                tdatv_q <= selDatv;
            end else if (bus.t_rdy) begin
                tvld_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (|bus.req_vld) begin
                        grantId_q <= winner_d;
                        beatCnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    if (accept) begin
                        beatCnt_q <= beatCnt_q + CW'(1);
                        if (releaseNow) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            rrPtr_q <= nextPtr_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_rdy = reqRdy_d;
    assign bus.tdat    = tdat_q;
    assign bus.tdatk   = tdatk_q;
    assign bus.tdatv   = tdatv_q;
    assign bus.tvld    = tvld_q;
    assign grant_id    = grantId_q;
    assign busy        = busy_q;

`ifdef TX_LANE_ARBITER_STATS_EN
    logic [31:0] statCnt_q [NREQ];

    // Saturating accepted-beat counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) statCnt_q[i] <= '0;
        end else if (stat_clr) begin
            for (int i = 0; i < NREQ; i++) statCnt_q[i] <= '0;
        end else if (accept && (statCnt_q[grantId_q] != 32'hFFFF_FFFF)) begin
            statCnt_q[grantId_q] <= statCnt_q[grantId_q] + 32'd1;
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_stat
        assign stat_beats[g*32 +: 32] = statCnt_q[g];
    end
`endif

endmodule
